// File: rtl/chameleon_vid_pkg.sv
// Shared Chameleon video-path types: RRRGGGBB and 8:8:8 pixel formats, the 3:3:2 -> 8:8:8
// expansion, the bank-swap state encoding and the default frame-buffer geometry.
package chameleon_vid_pkg;

  localparam int XW_DEF = 8;
  localparam int YW_DEF = 8;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_t;

  // Bit replication keeps full black at 0x00 and full white at 0xFF.
  function automatic rgb888_t expand332(input rgb332_t p);
    rgb888_t q;
    q.r = {p.r, p.r, p.r[2:1]};
    q.g = {p.g, p.g, p.g[2:1]};
    q.b = {4{p.b}};
    return q;
  endfunction

endpackage

// File: rtl/vram_dp.sv
// Simple dual-port frame-buffer RAM: one write port, one registered read port,
// read-before-write on a same-address collision. Shaped for block-RAM inference.
module vram_dp #(
  parameter int AW = 17,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: no reset on the array or its read register -- block RAM cannot be cleared in one
  // cycle, and picture contents must survive a core reset anyway.
  // NOTE: non-blocking assignments make the read sample the old word when it collides with
  // a write to the same address on the same edge (read-before-write).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vram_scanout.sv
// Chameleon frame-buffer scan-out: pixel writes, 2-clock read pipeline, 3:3:2 -> 8:8:8 expansion.
// Define CHAMELEON_DOUBLE_BUF_EN for two banks with a tear-free swap at vertical blank.
module vram_scanout
  import chameleon_vid_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter int YW = YW_DEF
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [XW-1:0] wr_x,
  input  logic [YW-1:0] wr_y,
  input  logic [7:0]    wr_data,
  input  logic          frame,
  input  logic          ce_pix,
  input  logic [8:0]    hcount,
  input  logic [8:0]    vcount,
  input  logic          hblank,
  input  logic          vblank,
  output logic [7:0]    r_out,
  output logic [7:0]    g_out,
  output logic [7:0]    b_out,
  output logic          de_out,
  output logic          bank_rd,
  output logic          swap_pending,
  output logic [7:0]    dropped
);

`ifdef CHAMELEON_DOUBLE_BUF_EN
  localparam int AW = XW + YW + 1;
`else
  localparam int AW = XW + YW;
`endif

  localparam logic [9:0] H_LIM = 10'(1 << XW);
  localparam logic [9:0] V_LIM = 10'(1 << YW);

  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] rd_addr_q;
  logic [7:0]    rd_data;
  logic          visible;
  logic          vis_q;
  logic          vis_q2;
  logic          ce_q;
  logic          ce_q2;
  rgb888_t       pix;

`ifdef CHAMELEON_DOUBLE_BUF_EN
  swap_state_t state;
  swap_state_t state_nx;
  logic        bank_nx;
  logic [7:0]  dropped_nx;
  logic        frame_q;
  logic        vblank_q;
  logic        frame_rise;
  logic        vblank_rise;

  assign frame_rise  = frame & ~frame_q;
  assign vblank_rise = vblank & ~vblank_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state    <= SWAP_IDLE;
      frame_q  <= 1'b0;
      vblank_q <= 1'b0;
      bank_rd  <= 1'b0;
      dropped  <= 8'd0;
    end else begin
      state    <= state_nx;
      frame_q  <= frame;
      vblank_q <= vblank;
      bank_rd  <= bank_nx;
      dropped  <= dropped_nx;
    end
  end

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      SWAP_IDLE:    if (frame_rise && !vblank_rise) state_nx = SWAP_PENDING;
      SWAP_PENDING: if (vblank_rise && !frame_rise) state_nx = SWAP_IDLE;
    endcase
  end

  // A coincident frame rise is swapped straight in from IDLE, or queued behind the swap in PENDING.
  always_comb begin
    swap_pending = (state == SWAP_PENDING);
    bank_nx      = bank_rd;
    dropped_nx   = dropped;
    if (vblank_rise && ((state == SWAP_PENDING) || frame_rise)) begin
      bank_nx = ~bank_rd;
    end
    if ((state == SWAP_PENDING) && frame_rise && !vblank_rise && (dropped != 8'hFF)) begin
      dropped_nx = dropped + 8'd1;
    end
  end

  assign wr_addr = {~bank_rd, wr_y, wr_x};
  assign rd_addr = {bank_rd, vcount[YW-1:0], hcount[XW-1:0]};
`else
  // Single bank: the core draws straight into the displayed picture.
  logic unused_frame;
  assign unused_frame = frame;

  assign bank_rd      = 1'b0;
  assign swap_pending = 1'b0;
  assign dropped      = 8'd0;
  assign wr_addr      = {wr_y, wr_x};
  assign rd_addr      = {vcount[YW-1:0], hcount[XW-1:0]};
`endif

  assign visible = ~hblank & ~vblank & ({1'b0, hcount} < H_LIM) & ({1'b0, vcount} < V_LIM);

  vram_dp #(
    .AW(AW),
    .DW(8)
  ) u_ram (
    .clk    (clk_sys),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr_q),
    .rd_data(rd_data)
  );

  // Address and visibility are captured on the pixel enable; ce_q/ce_q2 track that slot
  // through the RAM read so the outputs change exactly two clocks later and hold otherwise.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rd_addr_q <= '0;
      vis_q     <= 1'b0;
      vis_q2    <= 1'b0;
      ce_q      <= 1'b0;
      ce_q2     <= 1'b0;
    end else begin
      ce_q   <= ce_pix;
      ce_q2  <= ce_q;
      vis_q2 <= vis_q;
      if (ce_pix) begin
        rd_addr_q <= rd_addr;
        vis_q     <= visible;
      end
    end
  end

  assign pix = expand332(rgb332_t'(rd_data));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_out  <= 8'd0;
      g_out  <= 8'd0;
      b_out  <= 8'd0;
      de_out <= 1'b0;
    end else if (ce_q2) begin
      r_out  <= vis_q2 ? pix.r : 8'd0;
      g_out  <= vis_q2 ? pix.g : 8'd0;
      b_out  <= vis_q2 ? pix.b : 8'd0;
      de_out <= vis_q2;
    end
  end

endmodule

// File: tb/tb_vram_scanout.sv
// Self-checking bench for vram_scanout: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a frame-level behavioural model.
module tb_vram_scanout;

  localparam int XW = 8;
  localparam int YW = 8;
`ifdef CHAMELEON_DOUBLE_BUF_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  localparam int MW = XW + YW + 1;

  logic          clk_sys = 1'b0;
  logic          reset   = 1'b1;
  logic          wr_en   = 1'b0;
  logic [XW-1:0] wr_x    = '0;
  logic [YW-1:0] wr_y    = '0;
  logic [7:0]    wr_data = '0;
  logic          frame   = 1'b0;
  logic          ce_pix  = 1'b0;
  logic [8:0]    hcount  = '0;
  logic [8:0]    vcount  = '0;
  logic          hblank  = 1'b0;
  logic          vblank  = 1'b0;
  logic [7:0]    r_out, g_out, b_out;
  logic          de_out, bank_rd, swap_pending;
  logic [7:0]    dropped;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  vram_scanout #(.XW(XW), .YW(YW)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_data     (wr_data),
    .frame       (frame),
    .ce_pix      (ce_pix),
    .hcount      (hcount),
    .vcount      (vcount),
    .hblank      (hblank),
    .vblank      (vblank),
    .r_out       (r_out),
    .g_out       (g_out),
    .b_out       (b_out),
    .de_out      (de_out),
    .bank_rd     (bank_rd),
    .swap_pending(swap_pending),
    .dropped     (dropped)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [23:0] ref_expand(input logic [7:0] p);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = p[7:5];
    g = p[4:2];
    b = p[1:0];
    return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    logic [23:0] rgb;
    bit          de;
    bit          dc;
  } exp_t;

  bit   [7:0]    mmem   [1 << MW];
  bit            mknown [1 << MW];
  exp_t          pend_q [$];
  logic [23:0]   m_rgb  = '0;
  bit            m_de   = 1'b0;
  bit            m_dc   = 1'b0;
  bit            m_bank = 1'b0;
  bit            m_pend = 1'b0;
  int            m_drop = 0;
  bit            m_fprev, m_vprev, fr, vr, vis, kn;
  logic [MW-1:0] waddr, raddr;
  logic [7:0]    val;
  exp_t          e;
  int            cyc = 0;

  // Pixel value seen by a scan is the picture after this edge's write; it appears two edges later.
  initial begin
    forever begin
      @(posedge clk_sys);
      if (reset) begin
        m_bank = 1'b0; m_pend = 1'b0; m_drop = 0; m_fprev = 1'b0; m_vprev = 1'b0;
        m_rgb = '0; m_de = 1'b0; m_dc = 1'b0;
        pend_q.delete();
      end else begin
        fr    = frame && !m_fprev;
        vr    = vblank && !m_vprev;
        waddr = {(DB ? ~m_bank : 1'b0), wr_y, wr_x};
        if (ce_pix) begin
          raddr = {(DB ? m_bank : 1'b0), vcount[YW-1:0], hcount[XW-1:0]};
          vis   = !hblank && !vblank && (hcount < 9'd256) && (vcount < 9'd256);
          if (wr_en && (waddr == raddr)) begin
            val = wr_data; kn = 1'b1;
          end else begin
            val = mmem[raddr]; kn = mknown[raddr];
          end
          e.due = cyc + 2;
          e.rgb = vis ? ref_expand(val) : 24'd0;
          e.de  = vis;
          e.dc  = vis && !kn;
          pend_q.push_back(e);
        end
        if (wr_en) begin
          mmem[waddr]   = wr_data;
          mknown[waddr] = 1'b1;
        end
        while (pend_q.size() > 0 && pend_q[0].due == cyc) begin
          e = pend_q.pop_front();
          m_rgb = e.rgb; m_de = e.de; m_dc = e.dc;
        end
`ifdef CHAMELEON_DOUBLE_BUF_EN
        if (m_pend) begin
          if (vr) m_bank = ~m_bank;
          if (vr && !fr) m_pend = 1'b0;
          if (fr && !vr && m_drop < 255) m_drop++;
        end else if (fr && vr) begin
          m_bank = ~m_bank;
        end else if (fr) begin
          m_pend = 1'b1;
        end
`endif
        m_fprev = frame;
        m_vprev = vblank;
      end
      cyc++;
    end
  end

  // Every-cycle comparison, sampled between edges.
  initial begin
    forever begin
      @(posedge clk_sys);
      #2;
      if (cmp_en) begin
        check("model_de", 32'(de_out), 32'(m_de));
        if (!m_dc) check("model_rgb", 32'({r_out, g_out, b_out}), 32'(m_rgb));
        check("model_bank_rd", 32'(bank_rd), 32'(m_bank));
        check("model_swap_pending", 32'(swap_pending), 32'(m_pend));
        check("model_dropped", 32'(dropped), 32'(m_drop));
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step(input int n = 1);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic do_reset();
    wr_en = 1'b0; ce_pix = 1'b0; reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);
  endtask

  task automatic write_px(input int x, input int y, input logic [7:0] d);
    wr_en = 1'b1; wr_x = XW'(x); wr_y = YW'(y); wr_data = d;
    step(1);
    wr_en = 1'b0;
  endtask

  task automatic pulse_frame();
    frame = 1'b1; step(1); frame = 1'b0; step(1);
  endtask

  task automatic pulse_vblank();
    vblank = 1'b1; step(1); vblank = 1'b0; step(1);
  endtask

  task automatic scan(input int x, input int y);
    hcount = 9'(x); vcount = 9'(y); ce_pix = 1'b1;
    step(1);
    ce_pix = 1'b0;
    step(2);
  endtask

  task automatic check_px(input string name, input logic [23:0] exp_rgb, input bit exp_de);
    check({name, "_rgb"}, 32'({r_out, g_out, b_out}), 32'(exp_rgb));
    check({name, "_de"}, 32'(de_out), 32'(exp_de));
  endtask

  // Write a pixel, publish it (frame then vblank) and scan it back out.
  task automatic show(input logic [7:0] d, input string name, input logic [23:0] exp_rgb);
    write_px(5, 3, d);
    pulse_frame();
    pulse_vblank();
    scan(5, 3);
    check_px(name, exp_rgb, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    step(3);
    reset = 1'b0;
    step(1);
    cmp_en = 1'b1;

    check("reset_rgb", 32'({r_out, g_out, b_out}), 32'd0);
    check("reset_de", 32'(de_out), 32'd0);
    check("reset_bank_rd", 32'(bank_rd), 32'd0);
    check("reset_swap_pending", 32'(swap_pending), 32'd0);
    check("reset_dropped", 32'(dropped), 32'd0);

    check("pin_expand_e0", 32'(ref_expand(8'hE0)), 32'h00FF0000);
    check("pin_expand_1c", 32'(ref_expand(8'h1C)), 32'h0000FF00);
    check("pin_expand_03", 32'(ref_expand(8'h03)), 32'h000000FF);
    check("pin_expand_92", 32'(ref_expand(8'h92)), 32'h009292AA);

    // First frame: 0xE0 at (5,3), published, scanned with explicit latency checks.
    write_px(5, 3, 8'hE0);
    frame = 1'b1; step(1);
`ifdef CHAMELEON_DOUBLE_BUF_EN
    check("frame_rise_pending", 32'(swap_pending), 32'd1);
`else
    check("frame_ignored_pending", 32'(swap_pending), 32'd0);
`endif
    frame = 1'b0; step(1);
    pulse_vblank();
`ifdef CHAMELEON_DOUBLE_BUF_EN
    check("swap_bank_rd", 32'(bank_rd), 32'd1);
`else
    check("single_bank_rd", 32'(bank_rd), 32'd0);
`endif
    check("swap_done_pending", 32'(swap_pending), 32'd0);
    hcount = 9'd5; vcount = 9'd3; ce_pix = 1'b1;
    step(1);
    ce_pix = 1'b0;
    step(1);
    check("latency_early_de", 32'(de_out), 32'd0);
    step(1);
    check_px("px_e0", 24'hFF0000, 1'b1);

    show(8'h1C, "px_1c", 24'h00FF00);
    show(8'h03, "px_03", 24'h0000FF);
    show(8'h92, "px_92", 24'h9292AA);

    // Off-screen and blanked positions over a nonzero pixel.
    scan(256 + 5, 3);
    check_px("hcount_256", 24'h0, 1'b0);
    scan(5, 3);
    check_px("px_92_again", 24'h9292AA, 1'b1);
    hblank = 1'b1;
    scan(5, 3);
    check_px("hblank", 24'h0, 1'b0);
    hblank = 1'b0;
    scan(5, 256 + 3);
    check_px("vcount_256", 24'h0, 1'b0);

`ifdef CHAMELEON_DOUBLE_BUF_EN
    repeat (3) pulse_frame();
    check("drop_pending", 32'(swap_pending), 32'd1);
    check("drop_two", 32'(dropped), 32'd2);
    repeat (300) pulse_frame();
    check("drop_saturate", 32'(dropped), 32'd255);
    pulse_vblank();
    check("drop_swap_bank", 32'(bank_rd), 32'd1);
    check("drop_swap_pending", 32'(swap_pending), 32'd0);
    frame = 1'b1; vblank = 1'b1; step(1);
    frame = 1'b0; vblank = 1'b0; step(1);
    check("coincident_idle_bank", 32'(bank_rd), 32'd0);
    check("coincident_idle_pending", 32'(swap_pending), 32'd0);
    pulse_frame();
    frame = 1'b1; vblank = 1'b1; step(1);
    frame = 1'b0; vblank = 1'b0; step(1);
    check("coincident_pend_bank", 32'(bank_rd), 32'd1);
    check("coincident_pend_pending", 32'(swap_pending), 32'd1);
    check("coincident_pend_dropped", 32'(dropped), 32'd255);
`else
    repeat (3) pulse_frame();
    check("single_no_pending", 32'(swap_pending), 32'd0);
    check("single_no_dropped", 32'(dropped), 32'd0);
`endif

    // Reset while a swap is pending; the picture must survive.
    do_reset();
    check("rst_pending", 32'(swap_pending), 32'd0);
    check("rst_bank_rd", 32'(bank_rd), 32'd0);
    check("rst_dropped", 32'(dropped), 32'd0);
    scan(5, 3);
    check_px("rst_retained", 24'h9292AA, 1'b1);

`ifndef CHAMELEON_DOUBLE_BUF_EN
    write_px(7, 7, 8'h55);
    scan(7, 7);
    check_px("live_write", 24'h49B655, 1'b1);
    check("live_bank_rd", 32'(bank_rd), 32'd0);
`endif

    // Randomized phase: small address window so scans hit recent writes and collisions.
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      wr_en   = ($urandom_range(0, 1) == 0);
      wr_x    = XW'($urandom_range(0, 15));
      wr_y    = YW'($urandom_range(0, 7));
      wr_data = 8'($urandom);
      ce_pix  = ($urandom_range(0, 3) == 0);
      hblank  = ($urandom_range(0, 7) == 0);
      hcount  = ($urandom_range(0, 15) == 0) ? 9'($urandom_range(256, 300)) : 9'($urandom_range(0, 15));
      vcount  = ($urandom_range(0, 15) == 0) ? 9'($urandom_range(256, 270)) : 9'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) frame = ~frame;
      if ($urandom_range(0, 9) == 0) vblank = ~vblank;
      step(1);
    end
    wr_en = 1'b0; ce_pix = 1'b0;
    step(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
